// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: rotating-pointer priority search with a registered,
// held one-hot grant and an optional hold-time limit that forces a handoff.
module rr_grant_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 preempt
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HoldLast = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   id_q, id_d;
  logic            valid_q, valid_d;
  logic            preempt_q, preempt_d;

  logic [N-1:0]    others;
  logic [IW-1:0]   succ;
  logic            release_own;
  logic            force_hand;

  // First set bit of r, searching p, p+1, ..., wrapping modulo N.
  function automatic logic [IW-1:0] rr_search(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] res;
    logic          found;
    int unsigned   idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(p) + i) % N;
      if (!found && r[idx]) begin
        found = 1'b1;
        res   = IW'(idx);
      end
    end
    return res;
  endfunction

  always_comb begin
    others = '0;
    for (int unsigned i = 0; i < N; i++) begin
      others[i] = req[i] && (id_q != IW'(i));
    end
  end

  assign succ        = (int'(id_q) == N - 1) ? '0 : id_q + IW'(1);
  assign release_own = !req[id_q];
  assign force_hand  = req[id_q] && (MAX_HOLD != 0) && (hold_q == HoldLast) && (|others);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    id_d      = id_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          id_d    = rr_search(req, ptr_q);
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          id_d    = '0;
          valid_d = 1'b0;
        end
      end
      StGrant: begin
        if (release_own || force_hand) begin
          ptr_d  = succ;
          hold_d = '0;
          if (|others) begin
            id_d      = rr_search(others, succ);
            preempt_d = force_hand;
          end else begin
            state_d = StIdle;
            id_d    = '0;
            valid_d = 1'b0;
          end
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant_d[i] = valid_d && (id_d == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (N=4, MAX_HOLD=4) with a queue of expected outputs.
module tb_rr_grant_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic       p;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_grant_ctrl #(.N(4), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge, queue its expected outputs, then pop and compare after the edge.
  task automatic step(input logic [3:0] r, input logic rn, input logic [3:0] eg, input logic ep,
                      input string tag);
    exp_t       e;
    logic [1:0] eid;
    logic       ev;
    req     = r;
    reset_n = rn;
    sb.push_back('{g: eg, p: ep, tag: tag});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    eid = 2'd0;
    for (int i = 0; i < 4; i++) if (e.g[i]) eid = 2'(i);
    ev = (e.g != 4'b0000);
    checks++;
    assert (grant === e.g) else begin
      errors++;
      $error("FAIL %s grant got %b want %b", e.tag, grant, e.g);
    end
    checks++;
    assert (grant_valid === ev) else begin
      errors++;
      $error("FAIL %s grant_valid got %b want %b", e.tag, grant_valid, ev);
    end
    checks++;
    assert (grant_id === eid) else begin
      errors++;
      $error("FAIL %s grant_id got %0d want %0d", e.tag, grant_id, eid);
    end
    checks++;
    assert (preempt === e.p) else begin
      errors++;
      $error("FAIL %s preempt got %b want %b", e.tag, preempt, e.p);
    end
  endtask

  initial begin
    logic [3:0] oh;
    reset_n = 1'b0;
    req     = 4'b0000;

    // Reset holds everything low even with all requests up.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 4'b0000, 1'b0, "reset");
    step(4'b1111, 1'b1, 4'b0001, 1'b0, "first_grant");

    // Fairness: each owner keeps the grant 4 cycles, then a forced handoff.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 4'b0001, 1'b0, "fair_hold0");
    for (int k = 1; k <= 4; k++) begin
      oh = 4'b0001 << (k % 4);
      step(4'b1111, 1'b1, oh, 1'b1, "fair_handoff");
      if (k < 4) for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, oh, 1'b0, "fair_hold");
    end

    // Direct handoff on release with no idle cycle.
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "release_idle");
    step(4'b1100, 1'b1, 4'b0100, 1'b0, "direct_a");
    step(4'b1000, 1'b1, 4'b1000, 1'b0, "direct_b");

    // Lone owner keeps the grant past the limit, then yields once someone else asks.
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, 4'b0001, 1'b0, "lone_owner");
    step(4'b1001, 1'b1, 4'b1000, 1'b1, "lone_preempt");

    // Idle, then wrapped search from ptr=3 picks 3 ahead of 2.
    step(4'b0100, 1'b1, 4'b0100, 1'b0, "to_owner2");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_a");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_b");
    step(4'b1100, 1'b1, 4'b1000, 1'b0, "wrap_search");

    // Reset in the middle of a grant clears pointer and hold count.
    step(4'b0100, 1'b1, 4'b0100, 1'b0, "mid_a");
    step(4'b0100, 1'b1, 4'b0100, 1'b0, "mid_b");
    step(4'b0100, 1'b1, 4'b0100, 1'b0, "mid_c");
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "mid_reset");
    step(4'b1111, 1'b1, 4'b0001, 1'b0, "post_reset");
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 4'b0001, 1'b0, "post_hold");
    step(4'b1111, 1'b1, 4'b0010, 1'b1, "post_preempt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
